// File: rtl/rat_io_hub.sv
// Port-I/O hub for the RAT MCU: strobe-written output registers, an input read mux,
// and a debounced rising-edge interrupt controller with mask/pending registers.
module rat_io_hub #(
   parameter int         NUM_OUT     = 4,
   parameter int         NUM_IN      = 2,
   parameter int         NUM_IRQ     = 2,
   parameter int         DB_CYCLES   = 500000,
   parameter logic [7:0] OUT_BASE    = 8'h40,
   parameter logic [7:0] IN_BASE     = 8'hF8,
   parameter logic [7:0] IRQ_MASK_ID = 8'h20,
   parameter logic [7:0] IRQ_PEND_ID = 8'h21
) (
   input  logic                   CLK,
   input  logic                   RESET,
   input  logic [7:0]             PORT_ID,
   input  logic [7:0]             OUT_PORT,
   input  logic                   IO_STRB,
   output logic [7:0]             IN_PORT,
   input  logic [8*NUM_IN-1:0]    IN_DATA,
   output logic [8*NUM_OUT-1:0]   OUT_DATA,
   input  logic [NUM_IRQ-1:0]     IRQ_SRC,
   output logic                   INTR
);

   localparam int CW = $clog2(DB_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

   function automatic bit win_overlap(input int a0, input int n0, input int a1, input int n1);
      return (a0 < a1 + n1) && (a1 < a0 + n0);
   endfunction

   localparam int OB = int'(OUT_BASE);
   localparam int IB = int'(IN_BASE);
   localparam int MB = int'(IRQ_MASK_ID);
   localparam int PB = int'(IRQ_PEND_ID);

   localparam bit MAP_BAD =
      win_overlap(OB, NUM_OUT, IB, NUM_IN) || win_overlap(OB, NUM_OUT, MB, 1) ||
      win_overlap(OB, NUM_OUT, PB, 1)      || win_overlap(IB, NUM_IN, MB, 1)  ||
      win_overlap(IB, NUM_IN, PB, 1)       || win_overlap(MB, 1, PB, 1)       ||
      (OB + NUM_OUT > 256) || (IB + NUM_IN > 256);

   localparam bit RANGE_BAD = (NUM_OUT < 1) || (NUM_OUT > 16) || (NUM_IN < 1) || (NUM_IN > 8) ||
                              (NUM_IRQ < 1) || (NUM_IRQ > 8)  || (DB_CYCLES < 2);

   generate
      if (MAP_BAD) begin : g_map_err
         $error("rat_io_hub: port ID windows overlap or exceed 8'hFF");
      end
      if (RANGE_BAD) begin : g_range_err
         $error("rat_io_hub: parameter out of range");
      end
   endgenerate

   logic [NUM_OUT-1:0][7:0] out_q, out_d;
   logic [NUM_IRQ-1:0]      mask_q, mask_d;
   logic [NUM_IRQ-1:0]      pend_q, pend_d;
   logic [NUM_IRQ-1:0]      sync1_q, sync2_q;
   logic [NUM_IRQ-1:0]      db_q, db_d;
   logic [CW-1:0]           cnt_q [NUM_IRQ];
   logic [CW-1:0]           cnt_d [NUM_IRQ];
   logic                    intr_q, intr_d;
   logic [NUM_IRQ-1:0]      rise, clr;
   logic                    wr_mask, wr_pend;

   assign wr_mask = IO_STRB && (PORT_ID == IRQ_MASK_ID);
   assign wr_pend = IO_STRB && (PORT_ID == IRQ_PEND_ID);

   // 9-bit compare so a window near 8'hFF cannot alias onto low IDs
   genvar gi;
   generate
      for (gi = 0; gi < NUM_OUT; gi++) begin : g_out
         assign out_d[gi] = (IO_STRB && ({1'b0, PORT_ID} == 9'(OB + gi))) ? OUT_PORT : out_q[gi];
      end

      for (gi = 0; gi < NUM_IRQ; gi++) begin : g_db
         logic differ;
         assign differ     = sync2_q[gi] != db_q[gi];
         assign cnt_d[gi]  = (!differ || cnt_q[gi] == CNT_MAX) ? '0 : cnt_q[gi] + 1'b1;
         assign db_d[gi]   = (differ && cnt_q[gi] == CNT_MAX) ? sync2_q[gi] : db_q[gi];
      end
   endgenerate

   // a press landing on the same edge as its W1C still leaves the bit pending
   always_comb begin
      rise   = db_d & ~db_q;
      clr    = wr_pend ? OUT_PORT[NUM_IRQ-1:0] : '0;
      pend_d = (pend_q & ~clr) | rise;
      mask_d = wr_mask ? OUT_PORT[NUM_IRQ-1:0] : mask_q;
      intr_d = |(pend_q & mask_q);
   end

   always_comb begin
      IN_PORT = 8'h00;
      for (int k = 0; k < NUM_IN; k++) begin
         if ({1'b0, PORT_ID} == 9'(IB + k)) IN_PORT = IN_DATA[8*k +: 8];
      end
      if (PORT_ID == IRQ_MASK_ID) IN_PORT = 8'(mask_q);
      if (PORT_ID == IRQ_PEND_ID) IN_PORT = 8'(pend_q);
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         out_q   <= '0;
         mask_q  <= '0;
         pend_q  <= '0;
         sync1_q <= '0;
         sync2_q <= '0;
         db_q    <= '0;
         intr_q  <= 1'b0;
         for (int k = 0; k < NUM_IRQ; k++) cnt_q[k] <= '0;
      end else begin
         out_q   <= out_d;
         mask_q  <= mask_d;
         pend_q  <= pend_d;
         sync1_q <= IRQ_SRC;
         sync2_q <= sync1_q;
         db_q    <= db_d;
         intr_q  <= intr_d;
         for (int k = 0; k < NUM_IRQ; k++) cnt_q[k] <= cnt_d[k];
      end
   end

   assign OUT_DATA = out_q;
   assign INTR     = intr_q;

endmodule

// File: tb/tb_rat_io_hub.sv
// Scoreboard bench for rat_io_hub: a cycle-level reference model queues expectations,
// a monitor on the falling edge pops and compares OUT_DATA, INTR and IN_PORT.
module tb_rat_io_hub;
   localparam int DB = 4;

   logic        clk = 1'b0;
   logic        reset, io_strb, intr;
   logic [7:0]  port_id, out_port, in_port;
   logic [15:0] in_data;
   logic [31:0] out_data;
   logic [1:0]  irq_src;

   always #5 clk = ~clk;

   rat_io_hub #(.DB_CYCLES(DB)) dut (
      .CLK(clk), .RESET(reset), .PORT_ID(port_id), .OUT_PORT(out_port), .IO_STRB(io_strb),
      .IN_PORT(in_port), .IN_DATA(in_data), .OUT_DATA(out_data), .IRQ_SRC(irq_src), .INTR(intr)
   );

   typedef struct packed {
      logic [31:0] out;
      logic        intr;
      logic [7:0]  inp;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   logic [31:0] m_out;
   logic [1:0]  m_mask, m_pend, m_db, m_s1, m_s2;
   logic        m_intr;
   bit          m_win [2][DB];

   function automatic logic [7:0] m_read(input logic [7:0] id);
      case (id)
         8'hF8:   return in_data[7:0];
         8'hF9:   return in_data[15:8];
         8'h20:   return {6'b0, m_mask};
         8'h21:   return {6'b0, m_pend};
         default: return 8'h00;
      endcase
   endfunction

   // Reference model: a button qualifies once the last DB synchronised samples all disagree with db
   initial begin : model
      logic [1:0] rise, clr;
      bit         all_diff;
      int         idx;
      m_out = '0; m_mask = '0; m_pend = '0; m_db = '0; m_s1 = '0; m_s2 = '0; m_intr = 1'b0;
      forever begin
         @(posedge clk);
         if (reset) begin
            m_out = '0; m_mask = '0; m_pend = '0; m_db = '0; m_s1 = '0; m_s2 = '0; m_intr = 1'b0;
            for (int i = 0; i < 2; i++) for (int j = 0; j < DB; j++) m_win[i][j] = 1'b0;
         end else begin
            rise = '0;
            clr  = '0;
            for (int i = 0; i < 2; i++) begin
               for (int j = DB - 1; j > 0; j--) m_win[i][j] = m_win[i][j-1];
               m_win[i][0] = m_s2[i];
               all_diff = 1'b1;
               for (int j = 0; j < DB; j++) if (m_win[i][j] == m_db[i]) all_diff = 1'b0;
               if (all_diff) begin
                  m_db[i] = ~m_db[i];
                  if (m_db[i]) rise[i] = 1'b1;
               end
            end
            m_intr = |(m_pend & m_mask);
            if (io_strb) begin
               idx = int'(port_id) - 'h40;
               if (idx >= 0 && idx < 4) m_out[8*idx +: 8] = out_port;
               if (port_id == 8'h20) m_mask = out_port[1:0];
               if (port_id == 8'h21) clr = out_port[1:0];
            end
            m_pend = (m_pend & ~clr) | rise;
            m_s2 = m_s1;
            m_s1 = irq_src;
         end
         exp_q.push_back('{out: m_out, intr: m_intr, inp: m_read(port_id)});
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, req);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("out_data", out_data, e.out);
            chk("intr", {31'b0, intr}, {31'b0, e.intr});
            chk($sformatf("in_port[id=%h]", port_id), {24'b0, in_port}, {24'b0, e.inp});
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [7:0] id, input logic [7:0] d);
      tick();
      port_id = id; out_port = d; io_strb = 1'b1;
      $display("txn write id=%h data=%h", id, d);
      tick();
      io_strb = 1'b0; port_id = 8'h21;
   endtask

   task automatic rd(input logic [7:0] id);
      tick();
      port_id = id;
      $display("txn read id=%h", id);
   endtask

   function automatic logic [7:0] pick_id();
      case ($urandom_range(0, 11))
         0: return 8'h40;  1: return 8'h41;  2: return 8'h42;  3: return 8'h43;
         4: return 8'h44;  5: return 8'h20;  6: return 8'h21;  7: return 8'h21;
         8: return 8'hF8;  9: return 8'hF9;  10: return 8'hFF;
         default: return 8'($urandom);
      endcase
   endfunction

   initial begin : stim
      reset = 1'b1; io_strb = 1'b1; port_id = 8'h40; out_port = 8'hFF;
      irq_src = '0; in_data = '0;
      $display("txn reset with write 40<=ff");
      tick(2);
      reset = 1'b0; io_strb = 1'b0;
      rd(8'h20);
      rd(8'h21);

      wr(8'h40, 8'hA5);
      wr(8'h43, 8'h3C);
      wr(8'h44, 8'h77);

      in_data = {8'h12, 8'h34};
      rd(8'hF8);
      rd(8'hF9);
      rd(8'hFF);

      wr(8'h20, 8'h01);
      $display("txn glitch src0 3 cycles");
      irq_src[0] = 1'b1; tick(3); irq_src[0] = 1'b0; tick(10);
      $display("txn hold src0");
      irq_src[0] = 1'b1; tick(12);
      $display("txn release src0");
      irq_src[0] = 1'b0; tick(12);
      wr(8'h21, 8'h01);
      tick(2);

      wr(8'h20, 8'h00);
      $display("txn press src1 masked");
      irq_src[1] = 1'b1; tick(10); irq_src[1] = 1'b0; tick(10);
      wr(8'h20, 8'h02);
      tick(2);
      wr(8'h21, 8'h02);
      tick(3);

      $display("txn collision src0 press vs W1C");
      irq_src[0] = 1'b1;
      tick(4);
      wr(8'h21, 8'h01);
      tick(3);
      irq_src[0] = 1'b0; tick(10);
      wr(8'h21, 8'h03);
      $display("txn press both");
      irq_src = 2'b11; tick(10);
      irq_src = 2'b00; tick(10);
      wr(8'h21, 8'h03);

      $display("txn reset mid-debounce");
      irq_src[0] = 1'b1; tick(3);
      reset = 1'b1; tick(); reset = 1'b0;
      tick(10);
      irq_src[0] = 1'b0; tick(8);
      wr(8'h21, 8'h03);

      for (int n = 0; n < 400; n++) begin
         tick();
         io_strb  = ($urandom_range(0, 3) == 0);
         port_id  = pick_id();
         out_port = 8'($urandom);
         if ($urandom_range(0, 15) == 0) in_data = 16'($urandom);
         for (int b = 0; b < 2; b++) if ($urandom_range(0, 11) == 0) irq_src[b] = ~irq_src[b];
         reset = ($urandom_range(0, 149) == 0);
         $display("txn rand strb=%0b id=%h data=%h irq=%b rst=%0b", io_strb, port_id, out_port, irq_src, reset);
      end
      reset = 1'b0; io_strb = 1'b0;
      tick(4);
      if (exp_q.size() > 1) begin
         bad++;
         $display("FAIL drain: %0d expectations left, expected at most 1", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
